// File: rtl/ddr_region_loader.sv
// ddr_region_loader
// Walks up to NUM_REGION DDR regions in order and fills each one with a word stream, with zeros,
// or with a config word followed by zeros. Each word is split little-endian into write beats of
// BEAT_BYTES bytes on a byte-addressed write port.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            run request, sampled only while idle
//   region_base      absolute byte base per region (32 bits each)
//   region_len       words per region (0 skips the region)
//   region_mode      0 stream, 1 zero fill, 2 cfg word then zeros, 3 illegal
//   cfg_word         first word of mode-2 regions
//   src_data/valid   stream word input, accepted on src_valid & src_ready
//   src_ready        high only while waiting for a stream word
//   mem_addr/data/we write beat, held until mem_ready
//   mem_ready        beat accepted on mem_we & mem_ready
//   busy, done, err  status: not idle, one-cycle end pulse, sticky error
//   region_idx       region currently being processed
module ddr_region_loader #(
  parameter int unsigned NUM_REGION = 5,
  parameter int unsigned WORD_WIDTH = 128,
  parameter int unsigned BYTE_WIDTH = 8,
  parameter int unsigned BEAT_BYTES = 4,
  parameter int unsigned ADDR_WIDTH = 30,
  parameter int unsigned LEN_WIDTH  = 13,
  parameter logic [31:0] DDR_OFFSET = 32'h0800_0000,
  parameter int unsigned IDX_WIDTH  = (NUM_REGION > 1) ? $clog2(NUM_REGION) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [NUM_REGION*32-1:0]         region_base,
  input  logic [NUM_REGION*LEN_WIDTH-1:0]  region_len,
  input  logic [NUM_REGION*2-1:0]          region_mode,
  input  logic [WORD_WIDTH-1:0]            cfg_word,
  input  logic [WORD_WIDTH-1:0]            src_data,
  input  logic                             src_valid,
  output logic                             src_ready,
  output logic [ADDR_WIDTH-1:0]            mem_addr,
  output logic [BEAT_BYTES*BYTE_WIDTH-1:0] mem_data,
  output logic                             mem_we,
  input  logic                             mem_ready,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic [IDX_WIDTH-1:0]             region_idx
);

  localparam int unsigned WORD_BYTES = WORD_WIDTH / BYTE_WIDTH;
  localparam int unsigned BPW        = WORD_BYTES / BEAT_BYTES;
  localparam int unsigned BEAT_W     = BEAT_BYTES * BYTE_WIDTH;
  localparam int unsigned BCW        = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StFetch = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StNext  = 3'd4;
  localparam logic [2:0] StDone  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [IDX_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [1:0]            mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] word_q, word_d;
  logic [LEN_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [BCW-1:0]        beat_q, beat_d;
  logic                  we_q, we_d;
  logic                  rdy_q, rdy_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  // Region fields of the current index, only consumed in StLoad.
  logic [31:0]           cur_base;
  logic [LEN_WIDTH-1:0]  cur_len;
  logic [1:0]            cur_mode;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [63:0]           region_end;
  logic                  out_of_range;
  logic [LEN_WIDTH-1:0]  wcnt_inc;
  logic [WORD_WIDTH-1:0] fill_word;

  always_comb begin
    cur_base     = region_base[32*idx_q +: 32];
    cur_len      = region_len[LEN_WIDTH*idx_q +: LEN_WIDTH];
    cur_mode     = region_mode[2*idx_q +: 2];
    cur_addr     = ADDR_WIDTH'(cur_base - DDR_OFFSET);
    // Wide arithmetic so the end-of-region check cannot wrap.
    region_end   = 64'(cur_addr) + 64'(cur_len) * 64'(WORD_BYTES);
    out_of_range = region_end > (64'd1 << ADDR_WIDTH);
    wcnt_inc     = wcnt_q + LEN_WIDTH'(1);
    fill_word    = (mode_q == 2'd2 && wcnt_q == '0) ? cfg_word : '0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    mode_d  = mode_q;
    addr_d  = addr_q;
    word_d  = word_q;
    wcnt_d  = wcnt_q;
    beat_d  = beat_q;
    we_d    = we_q;
    rdy_d   = rdy_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          idx_d   = '0;
          err_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StLoad: begin
        len_d  = cur_len;
        mode_d = cur_mode;
        addr_d = cur_addr;
        wcnt_d = '0;
        beat_d = '0;
        if (cur_len == '0) begin
          state_d = StNext;
        end else if (cur_mode == 2'd3 || cur_base < DDR_OFFSET || out_of_range) begin
          err_d   = 1'b1;
          state_d = StNext;
        end else begin
          state_d = StFetch;
          rdy_d   = (cur_mode == 2'd0);
        end
      end
      StFetch: begin
        if (mode_q == 2'd0) begin
          if (src_valid && rdy_q) begin
            word_d  = src_data;
            rdy_d   = 1'b0;
            we_d    = 1'b1;
            state_d = StWrite;
          end
        end else begin
          word_d  = fill_word;
          we_d    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (mem_ready) begin
          addr_d = addr_q + ADDR_WIDTH'(BEAT_BYTES);
          if (beat_q == BCW'(BPW - 1)) begin
            beat_d = '0;
            we_d   = 1'b0;
            wcnt_d = wcnt_inc;
            if (wcnt_inc == len_q) begin
              state_d = StNext;
            end else begin
              state_d = StFetch;
              rdy_d   = (mode_q == 2'd0);
            end
          end else begin
            beat_d = beat_q + BCW'(1);
            // Lowest beat of word_q drives mem_data, so shifting exposes the next beat.
            word_d = word_q >> BEAT_W;
          end
        end
      end
      StNext: begin
        if (idx_q == IDX_WIDTH'(NUM_REGION - 1)) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          idx_d   = idx_q + IDX_WIDTH'(1);
          state_d = StLoad;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      len_q   <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      wcnt_q  <= '0;
      beat_q  <= '0;
      we_q    <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      wcnt_q  <= wcnt_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign src_ready  = rdy_q;
  assign mem_addr   = addr_q;
  assign mem_data   = word_q[BEAT_W-1:0];
  assign mem_we     = we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign region_idx = idx_q;

endmodule
